// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter sharing one cache request path among NUM_REQ cores.
// Optional tenure limit enabled by defining ARB_TIMEOUT_EN.
module cache_bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout,
  output logic [ID_W-1:0]    timeout_id
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] pick_id;
  logic            pick_vld;
  logic [ID_W-1:0] ptr_nxt;
  logic            own_rel;
  logic            force_rel;

  // Scan from ptr upward; iterate farthest-first so the nearest hit wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

  assign own_rel = ~req[gnt_id] | done[gnt_id];
  assign ptr_nxt = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [CW-1:0] hold_cnt;

  assign force_rel = (hold_cnt == CW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt   <= '0;
      timeout    <= 1'b0;
      timeout_id <= '0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        hold_cnt <= '0;
      end else if (!own_rel && force_rel) begin
        // A normal release on the limit cycle wins; only pure overruns flag.
        timeout    <= 1'b1;
        timeout_id <= gnt_id;
        hold_cnt   <= '0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign force_rel  = 1'b0;
  assign timeout    = 1'b0;
  assign timeout_id = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt    <= NUM_REQ'(1) << pick_id;
            gnt_id <= pick_id;
            busy   <= 1'b1;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (own_rel || force_rel) begin
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= ptr_nxt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter; timeout section follows ARB_TIMEOUT_EN.
module tb_cache_bus_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               busy;
  logic               timeout;
  logic [ID_W-1:0]    timeout_id;

  int checks = 0;
  int errors = 0;

  cache_bus_arbiter #(.NUM_REQ(NUM_REQ), .MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .gnt(gnt), .gnt_id(gnt_id),
    .busy(busy), .timeout(timeout), .timeout_id(timeout_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int o;
    rst  = 1'b1;
    req  = 4'b1111;
    done = 4'b0000;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gnt_id", 32'(gnt_id), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;
    tick();
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_busy", 32'(busy), 32'h1);

    // Rotation 0,1,2,3,0 with 3-cycle tenures and a dead cycle between.
    for (int k = 0; k < 5; k++) begin
      o = k % 4;
      tick();
      tick();
      chk("rot_hold", 32'(gnt), 32'h1 << o);
      chk("rot_id", 32'(gnt_id), 32'(o));
      done = 4'b0001 << o;
      tick();
      done = 4'b0000;
      chk("rot_dead_gnt", 32'(gnt), 32'h0);
      chk("rot_dead_busy", 32'(busy), 32'h0);
      tick();
      chk("rot_next", 32'(gnt), 32'h1 << ((o + 1) % 4));
    end

    // Core1 owns; hand off to core2.
    done = 4'b0010;
    tick();
    done = 4'b0000;
    tick();
    chk("hold_own2", 32'(gnt), 32'h4);
    req  = 4'b0110;
    done = 4'b0010;
    tick();
    done = 4'b0000;
    chk("hold_ignore", 32'(gnt), 32'h4);
    chk("hold_id", 32'(gnt_id), 32'h2);
    req = 4'b0100;
    tick();
    req = 4'b0110;
    tick();
    chk("hold_ignore2", 32'(gnt), 32'h4);
    done = 4'b0100;
    tick();
    done = 4'b0000;
    chk("hold_rel", 32'(gnt), 32'h0);
    tick();
    chk("hold_next1", 32'(gnt), 32'h2);

    // Drop req[1] to release, then core2, then steer ptr to 3 for the wrap.
    req = 4'b0100;
    tick();
    chk("drop_rel", 32'(busy), 32'h0);
    tick();
    chk("drop_next2", 32'(gnt), 32'h4);
    req = 4'b1001;
    tick();
    chk("wrap_dead", 32'(gnt), 32'h0);
    tick();
    chk("wrap_gnt3", 32'(gnt), 32'h8);
    chk("wrap_id3", 32'(gnt_id), 32'h3);
    done = 4'b1000;
    tick();
    done = 4'b0000;
    tick();
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    chk("wrap_id0", 32'(gnt_id), 32'h0);

    // done and req fall together: single release, then idle.
    req  = 4'b0000;
    done = 4'b0001;
    tick();
    done = 4'b0000;
    chk("sim_rel", 32'(busy), 32'h0);
    tick();
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // Long tenure by core1 (ptr=1).
    req = 4'b0110;
    tick();
    chk("long_gnt1", 32'(gnt), 32'h2);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    chk("to_still", 32'(gnt), 32'h2);
    chk("to_not_yet", 32'(timeout), 32'h0);
    tick();
    chk("to_drop", 32'(gnt), 32'h0);
    chk("to_pulse", 32'(timeout), 32'h1);
    chk("to_id", 32'(timeout_id), 32'h1);
    tick();
    chk("to_end", 32'(timeout), 32'h0);
    chk("to_next2", 32'(gnt), 32'h4);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("long_hold", 32'(gnt), 32'h2);
    chk("long_no_to", 32'(timeout), 32'h0);
    chk("long_no_to_id", 32'(timeout_id), 32'h0);
    done = 4'b0010;
    tick();
    done = 4'b0000;
    tick();
    chk("long_next2", 32'(gnt), 32'h4);
`endif

    // Reset mid-tenure, then ptr restarts at 0.
    rst = 1'b1;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'h2);
    chk("post_rst_id", 32'(gnt_id), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
